seg_write_arbiter: RTL and testbench
====================================

Name: seg_write_arbiter

Overview:
Arbitrates write access to the four segment registers (ES, CS, SS, DS) among three requesters:
- INT: interrupt unit, CS load from the vector.
- FAR: far JMP/CALL/RET unit.
- EU: execution unit, MOV Sreg / POP Sreg.

It drives the per-register ENA strobes and the shared 16-bit D bus of the segment register instances. It defers writes while a bus cycle is using segment values, and generates the 8086-style interrupt inhibit after an SS load.

Parameters:
- STARVE_LIMIT, 4, number of consecutive lost arbitrations after which the EU request is promoted to top priority for one grant.
- CNT_W, 3, width of the EU starvation counter; must satisfy 2^CNT_W > STARVE_LIMIT.

Ports:
- CLK  input  1  clock, all logic on rising edge
- RST  input  1  synchronous, active-high reset
- int_req  input  1  INT write request
- int_sel  input  2  INT target segment (00 ES, 01 CS, 10 SS, 11 DS)
- int_data  input  16  INT write data
- int_ack  output  1  INT grant/completion pulse
- far_req, far_sel, far_data, far_ack  (as INT, widths 1/2/16/1)
- eu_req, eu_sel, eu_data, eu_ack  (as INT, widths 1/2/16/1)
- bus_active  input  1  BIU bus cycle in progress; new grants are blocked while high
- instr_done  input  1  one-cycle pulse at each instruction boundary
- ENA_ES, ENA_CS, ENA_SS, ENA_DS  output  1 each  write enables to the segment registers
- seg_d  output  16  shared data to the segment register D inputs
- int_inhibit  output  1  interrupt recognition blocked
- busy  output  1  high in WRITE state

Behaviour:
- Reset (RST=1 at an edge): state=IDLE; all ENA_*=0; seg_d=0; all *_ack=0; int_inhibit=0; starvation counter=0. Reset in the WRITE cycle takes effect at that edge: ENA and ack drop the next cycle and no write is completed.
- FSM has two states, IDLE and WRITE. All outputs are registered.
- IDLE -> WRITE: at an edge where at least one req=1 and bus_active=0.
  - The winner's sel and data are latched.
  - In the WRITE cycle: exactly one ENA_* is high (decoded from the latched sel); seg_d = latched data; the winner's ack=1; busy=1.
- WRITE -> IDLE unconditionally after one cycle. Sustained back-to-back grants therefore come every 2 cycles. Requests sampled during WRITE are ignored.
- Requester protocol:
  - Hold req, sel and data stable until ack is seen.
  - Deassert req in the cycle after ack, or keep it high to request again.
  - Any req dropped before ack is lost.
- While bus_active=1, IDLE holds and ENA_* stay 0. A WRITE already entered completes regardless of bus_active.
- Priority: INT > FAR > EU.
  - Exception: if the starvation counter ≥ STARVE_LIMIT and eu_req=1, EU wins.
  - Counter increments (saturating) on each grant to INT or FAR while eu_req=1.
  - Counter clears on an EU grant, or on any grant with eu_req=0.
- Two requesters targeting the same segment are not merged. Each is granted separately in priority order, so the later write overwrites the earlier.
- seg_d holds its last value outside WRITE; ENA_* are 0 outside WRITE.
- int_inhibit:
  - Set at the edge ending a WRITE with sel=10 (SS).
  - Cleared at the first edge where instr_done=1 and int_inhibit is already 1.
  - If set and clear conditions coincide, set wins.
  - An instr_done arriving during the WRITE-to-SS cycle does not clear the inhibit.

Test Plan:
1. Reset, then eu_req=1, eu_sel=00, eu_data=0x1234, bus_active=0 → cycle+1: ENA_ES=1, seg_d=0x1234, eu_ack=1, busy=1; cycle+2: all ENA 0, busy=0.
2. int_req, far_req and eu_req all asserted together (sels 01/01/11, data 0xF000/0x2000/0x3000) → grants in order INT (ENA_CS, 0xF000), FAR (ENA_CS, 0x2000), EU (ENA_DS, 0x3000), one every 2 cycles, each ack a single pulse.
3. eu_req held with FAR requesting continuously, STARVE_LIMIT=4 → four FAR grants, then an EU grant even though far_req=1; counter reads 0 after the EU grant.
4. bus_active=1 for 5 cycles while eu_req=1 → no ENA or ack during those cycles; grant occurs on the cycle after bus_active falls.
5. EU writes SS=0x9000 → int_inhibit=1 the cycle after WRITE. An instr_done in the WRITE cycle leaves int_inhibit=1. The next instr_done pulse clears it at that edge.
6. RST asserted in the WRITE cycle of a DS write → next cycle all ENA_*=0, acks=0, int_inhibit=0, state IDLE; a still-asserted request is re-granted once RST is released.

Source files
------------

// File: rtl/seg_write_arbiter_if.sv
// ---------------------------------------------------------------------------
// seg_write_arbiter_if
//   Bundles the segment-write arbiter's requester handshakes, BIU status
//   inputs and segment-register write outputs.
//
//   Signals
//     int_* / far_* / eu_*   req, sel[1:0], data[15:0] toward the arbiter,
//                            ack back to the requester
//     bus_active             BIU bus cycle in progress (blocks new grants)
//     instr_done             one-cycle pulse at each instruction boundary
//     ENA_ES/CS/SS/DS        per-register write enables
//     seg_d                  shared data to the segment register D inputs
//     int_inhibit            interrupt recognition blocked after an SS load
//     busy                   arbiter is in its WRITE cycle
//
//   Modports
//     slave   arbiter side
//     master  requester / environment side
// ---------------------------------------------------------------------------
interface seg_write_arbiter_if;
    logic        int_req;
    logic [1:0]  int_sel;
    logic [15:0] int_data;
    logic        int_ack;

    logic        far_req;
    logic [1:0]  far_sel;
    logic [15:0] far_data;
    logic        far_ack;

    logic        eu_req;
    logic [1:0]  eu_sel;
    logic [15:0] eu_data;
    logic        eu_ack;

    logic        bus_active;
    logic        instr_done;

    logic        ENA_ES;
    logic        ENA_CS;
    logic        ENA_SS;
    logic        ENA_DS;
    logic [15:0] seg_d;
    logic        int_inhibit;
    logic        busy;

    modport slave (
        input  int_req, int_sel, int_data,
        input  far_req, far_sel, far_data,
        input  eu_req, eu_sel, eu_data,
        input  bus_active, instr_done,
        output int_ack, far_ack, eu_ack,
        output ENA_ES, ENA_CS, ENA_SS, ENA_DS, seg_d, int_inhibit, busy
    );

    modport master (
        output int_req, int_sel, int_data,
        output far_req, far_sel, far_data,
        output eu_req, eu_sel, eu_data,
        output bus_active, instr_done,
        input  int_ack, far_ack, eu_ack,
        input  ENA_ES, ENA_CS, ENA_SS, ENA_DS, seg_d, int_inhibit, busy
    );
endinterface

// File: rtl/seg_write_arbiter.sv
// ---------------------------------------------------------------------------
// seg_write_arbiter
//   Arbitrates writes to the ES/CS/SS/DS segment registers among the
//   interrupt unit (INT), the far JMP/CALL/RET unit (FAR) and the execution
//   unit (EU). A grant takes one WRITE cycle in which exactly one ENA strobe
//   is high, seg_d carries the winner's data and the winner sees a one-cycle
//   ack. New grants are held off while the BIU is running a bus cycle.
//   After an SS load, interrupt recognition is inhibited until the next
//   instruction boundary.
//
//   Ports
//     CLK   rising-edge clock
//     RST   synchronous, active-high reset
//     bus   seg_write_arbiter_if.slave (requesters, BIU status, outputs)
//
//   Parameters
//     STARVE_LIMIT  consecutive lost arbitrations before EU is promoted
//     CNT_W         starvation counter width, 2**CNT_W > STARVE_LIMIT
// ---------------------------------------------------------------------------
module seg_write_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic                CLK,
    input  logic                RST,
    seg_write_arbiter_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    // Requester index, also the bit position in the ack vector.
    typedef enum logic [1:0] {
        WIN_INT = 2'd0,
        WIN_FAR = 2'd1,
        WIN_EU  = 2'd2
    } win_e;

    localparam logic [1:0]       SEL_SS  = 2'b10;
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_e             state_q, state_d;
    logic [1:0]         sel_q, sel_d;
    logic [15:0]        seg_d_q, seg_d_d;
    logic [3:0]         ena_q, ena_d;      // {DS, SS, CS, ES}
    logic [2:0]         ack_q, ack_d;      // {EU, FAR, INT}
    logic               inhibit_q, inhibit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               any_req;
    logic               eu_promote;
    win_e               win;
    logic [1:0]         win_sel;
    logic [15:0]        win_data;

    assign any_req    = bus.int_req | bus.far_req | bus.eu_req;
    assign eu_promote = bus.eu_req && (cnt_q >= LIMIT_C);

    // Winner selection: INT > FAR > EU, except a starved EU jumps the queue.
    always_comb begin
        win = WIN_EU;
        if (eu_promote)       win = WIN_EU;
        else if (bus.int_req) win = WIN_INT;
        else if (bus.far_req) win = WIN_FAR;

        case (win)
            WIN_INT: begin
                win_sel  = bus.int_sel;
                win_data = bus.int_data;
            end
            WIN_FAR: begin
                win_sel  = bus.far_sel;
                win_data = bus.far_data;
            end
            default: begin
                win_sel  = bus.eu_sel;
                win_data = bus.eu_data;
            end
        endcase
    end

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned; an unassigned path would infer a latch.
        state_d   = state_q;
        sel_d     = sel_q;
        seg_d_d   = seg_d_q;
        ena_d     = '0;
        ack_d     = '0;
        cnt_d     = cnt_q;
        inhibit_d = inhibit_q;

        case (state_q)
            IDLE: begin
                if (any_req && !bus.bus_active) begin
                    state_d     = WRITE;
                    sel_d       = win_sel;
                    seg_d_d     = win_data;
                    ena_d       = 4'b0001 << win_sel;
                    ack_d[win]  = 1'b1;
                    // EU only counts as starved when it lost while asking.
                    if (win == WIN_EU || !bus.eu_req)
                        cnt_d = '0;
                    else if (cnt_q != CNT_MAX)
                        cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // A single write cycle; requests seen here are not considered.
                state_d = IDLE;
            end
        endcase

        // The SS-load set takes precedence, so an instruction boundary that
        // coincides with the SS write cycle leaves the inhibit in place.
        if (state_q == WRITE && sel_q == SEL_SS)
            inhibit_d = 1'b1;
        else if (bus.instr_done && inhibit_q)
            inhibit_d = 1'b0;
    end

    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (RST) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            seg_d_q   <= '0;
            ena_q     <= '0;
            ack_q     <= '0;
            inhibit_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            seg_d_q   <= seg_d_d;
            ena_q     <= ena_d;
            ack_q     <= ack_d;
            inhibit_q <= inhibit_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.ENA_ES      = ena_q[0];
    assign bus.ENA_CS      = ena_q[1];
    assign bus.ENA_SS      = ena_q[2];
    assign bus.ENA_DS      = ena_q[3];
    assign bus.seg_d       = seg_d_q;
    assign bus.int_ack     = ack_q[WIN_INT];
    assign bus.far_ack     = ack_q[WIN_FAR];
    assign bus.eu_ack      = ack_q[WIN_EU];
    assign bus.int_inhibit = inhibit_q;
    assign bus.busy        = (state_q == WRITE);

endmodule

// File: tb/tb_seg_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_seg_write_arbiter
//   Directed stimulus for seg_write_arbiter. Each expected grant is queued
//   as it is arranged; a negedge monitor pops and compares every cycle in
//   which the arbiter shows an ENA strobe or an ack.
// ---------------------------------------------------------------------------
module tb_seg_write_arbiter;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    seg_write_arbiter_if bus ();

    seg_write_arbiter #(
        .STARVE_LIMIT (4),
        .CNT_W        (3)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    // Expected grant record: ena {DS,SS,CS,ES}, data, ack {EU,FAR,INT}, busy.
    typedef struct packed {
        logic [3:0]  ena;
        logic [15:0] data;
        logic [2:0]  ack;
        logic        busy;
    } grant_t;

    localparam int W_INT = 0;
    localparam int W_FAR = 1;
    localparam int W_EU  = 2;

    grant_t exp_q[$];
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic grant_t mk(input logic [3:0] ena, input logic [15:0] data, input int who);
        grant_t g;
        g.ena  = ena;
        g.data = data;
        g.ack  = 3'b001 << who;
        g.busy = 1'b1;
        return g;
    endfunction

    function automatic logic [3:0] ena_now();
        return {bus.ENA_DS, bus.ENA_SS, bus.ENA_CS, bus.ENA_ES};
    endfunction

    function automatic logic [2:0] ack_now();
        return {bus.eu_ack, bus.far_ack, bus.int_ack};
    endfunction

    // Scoreboard monitor.
    always @(negedge CLK) begin
        grant_t act;
        grant_t e;
        act = {ena_now(), bus.seg_d, ack_now(), bus.busy};
        if ((ena_now() | {1'b0, ack_now()}) != 4'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected grant", 32'(act), 32'h0);
            end else begin
                e = exp_q.pop_front();
                check("grant", 32'(act), 32'(e));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Advance until the given requester's ack is visible; ticks returns the
    // number of edges it took.
    task automatic wait_ack(input int who, input int budget, input string name, output int ticks);
        ticks = 0;
        do begin
            tick();
            ticks++;
        end while (!ack_now()[who] && ticks < budget);
        check(name, 32'(ack_now()[who]), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;

        RST            = 1'b1;
        bus.int_req    = 1'b0; bus.int_sel = 2'b00; bus.int_data = 16'h0;
        bus.far_req    = 1'b0; bus.far_sel = 2'b00; bus.far_data = 16'h0;
        bus.eu_req     = 1'b0; bus.eu_sel  = 2'b00; bus.eu_data  = 16'h0;
        bus.bus_active = 1'b0;
        bus.instr_done = 1'b0;
        repeat (3) tick();

        // Reset state.
        check("reset ena", 32'(ena_now()), 32'h0);
        check("reset ack", 32'(ack_now()), 32'h0);
        check("reset seg_d", 32'(bus.seg_d), 32'h0);
        check("reset inhibit", 32'(bus.int_inhibit), 32'h0);
        check("reset busy", 32'(bus.busy), 32'h0);
        check("reset counter", 32'(dut.cnt_q), 32'h0);
        RST = 1'b0;
        tick();

        // 1: single EU write to ES.
        exp_q.push_back(mk(4'b0001, 16'h1234, W_EU));
        bus.eu_req = 1'b1; bus.eu_sel = 2'b00; bus.eu_data = 16'h1234;
        wait_ack(W_EU, 4, "t1 eu ack", t);
        check("t1 latency", 32'(t), 32'h1);
        check("t1 busy", 32'(bus.busy), 32'h1);
        bus.eu_req = 1'b0;
        tick();
        check("t1 ena after", 32'(ena_now()), 32'h0);
        check("t1 busy after", 32'(bus.busy), 32'h0);
        check("t1 seg_d held", 32'(bus.seg_d), 32'h1234);

        // 2: all three at once, priority order INT, FAR, EU.
        exp_q.push_back(mk(4'b0010, 16'hF000, W_INT));
        exp_q.push_back(mk(4'b0010, 16'h2000, W_FAR));
        exp_q.push_back(mk(4'b1000, 16'h3000, W_EU));
        bus.int_req = 1'b1; bus.int_sel = 2'b01; bus.int_data = 16'hF000;
        bus.far_req = 1'b1; bus.far_sel = 2'b01; bus.far_data = 16'h2000;
        bus.eu_req  = 1'b1; bus.eu_sel  = 2'b11; bus.eu_data  = 16'h3000;
        wait_ack(W_INT, 4, "t2 int ack", t);
        check("t2 int latency", 32'(t), 32'h1);
        bus.int_req = 1'b0;
        wait_ack(W_FAR, 4, "t2 far ack", t);
        check("t2 far spacing", 32'(t), 32'h2);
        bus.far_req = 1'b0;
        wait_ack(W_EU, 4, "t2 eu ack", t);
        check("t2 eu spacing", 32'(t), 32'h2);
        bus.eu_req = 1'b0;
        tick();

        // 3: EU starvation against a continuously requesting FAR.
        for (int i = 0; i < 4; i++) exp_q.push_back(mk(4'b1000, 16'h2222, W_FAR));
        exp_q.push_back(mk(4'b0001, 16'h5555, W_EU));
        exp_q.push_back(mk(4'b1000, 16'h2222, W_FAR));
        bus.far_req = 1'b1; bus.far_sel = 2'b11; bus.far_data = 16'h2222;
        bus.eu_req  = 1'b1; bus.eu_sel  = 2'b00; bus.eu_data  = 16'h5555;
        for (int i = 0; i < 4; i++) begin
            wait_ack(W_FAR, 4, "t3 far ack", t);
            check("t3 far counter", 32'(dut.cnt_q), 32'(i + 1));
        end
        wait_ack(W_EU, 4, "t3 promoted eu ack", t);
        check("t3 eu spacing", 32'(t), 32'h2);
        check("t3 counter cleared", 32'(dut.cnt_q), 32'h0);
        bus.eu_req = 1'b0;
        wait_ack(W_FAR, 4, "t3 far after eu", t);
        bus.far_req = 1'b0;
        tick();

        // 4: bus_active holds off the grant.
        bus.bus_active = 1'b1;
        bus.eu_req = 1'b1; bus.eu_sel = 2'b01; bus.eu_data = 16'h4444;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4 blocked", 32'({ena_now(), ack_now()}), 32'h0);
        end
        exp_q.push_back(mk(4'b0010, 16'h4444, W_EU));
        bus.bus_active = 1'b0;
        wait_ack(W_EU, 4, "t4 eu ack", t);
        check("t4 latency after release", 32'(t), 32'h1);
        bus.eu_req = 1'b0;
        tick();

        // 5: SS load and interrupt inhibit.
        exp_q.push_back(mk(4'b0100, 16'h9000, W_EU));
        bus.eu_req = 1'b1; bus.eu_sel = 2'b10; bus.eu_data = 16'h9000;
        wait_ack(W_EU, 4, "t5 eu ack", t);
        check("t5 inhibit in write", 32'(bus.int_inhibit), 32'h0);
        bus.eu_req = 1'b0;
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        check("t5 inhibit set", 32'(bus.int_inhibit), 32'h1);
        tick();
        tick();
        check("t5 inhibit held", 32'(bus.int_inhibit), 32'h1);
        bus.instr_done = 1'b1;
        tick();
        bus.instr_done = 1'b0;
        check("t5 inhibit cleared", 32'(bus.int_inhibit), 32'h0);

        // 6: reset during a DS write cycle.
        exp_q.push_back(mk(4'b0100, 16'h8000, W_EU));
        bus.eu_req = 1'b1; bus.eu_sel = 2'b10; bus.eu_data = 16'h8000;
        wait_ack(W_EU, 4, "t6 ss ack", t);
        bus.eu_req = 1'b0;
        tick();
        check("t6 inhibit before rst", 32'(bus.int_inhibit), 32'h1);
        exp_q.push_back(mk(4'b1000, 16'h7777, W_EU));
        bus.eu_req = 1'b1; bus.eu_sel = 2'b11; bus.eu_data = 16'h7777;
        wait_ack(W_EU, 4, "t6 ds ack", t);
        RST = 1'b1;
        tick();
        check("t6 rst ena", 32'(ena_now()), 32'h0);
        check("t6 rst ack", 32'(ack_now()), 32'h0);
        check("t6 rst inhibit", 32'(bus.int_inhibit), 32'h0);
        check("t6 rst busy", 32'(bus.busy), 32'h0);
        check("t6 rst seg_d", 32'(bus.seg_d), 32'h0);
        exp_q.push_back(mk(4'b1000, 16'h7777, W_EU));
        RST = 1'b0;
        wait_ack(W_EU, 4, "t6 regrant ack", t);
        check("t6 regrant latency", 32'(t), 32'h1);
        bus.eu_req = 1'b0;
        tick();
        tick();

        check("pending grants", 32'(exp_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
